// File: rtl/canny_pkg.sv
// Types and constants shared by the column feeder and the Sobel/gradient stages.
package canny_pkg;

  localparam int PIX_W = 8;
  localparam int COL_N = 5;

  // Rows that must already be stored before a column carries real data.
  localparam logic [2:0] FILL_FULL = 3'd4;

  typedef logic [0:COL_N-1][PIX_W-1:0] pix_col_t;

endpackage

// File: rtl/line_ram.sv
// One image row of pixel storage: asynchronous read, synchronous write at the same address.
module line_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Contents are deliberately left unreset; the feeder's fill count keeps stale data off the output.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/grad_col_feeder.sv
// Raster pixel stream in, 5-row vertical columns out; four chained line buffers hold the previous rows.
module grad_col_feeder
  import canny_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int PIX_W = canny_pkg::PIX_W,
  localparam int X_W  = $clog2(IMG_W)
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [PIX_W-1:0]                 px_in,
  input  logic                             px_valid,
  input  logic                             px_sof,
  output logic                             px_ready,
  output logic [0:COL_N-1][PIX_W-1:0]      col_out,
  output logic [X_W-1:0]                   col_x,
  output logic                             col_eol,
  output logic                             col_valid,
  input  logic                             col_ready
);

  logic [X_W-1:0]   x;
  logic [2:0]       fill;
  logic [X_W-1:0]   x_use;
  logic [2:0]       fill_use;
  logic             x_last;
  logic             accept;
  logic             xfer;
  logic [PIX_W-1:0] lb_rd [4];
  logic [PIX_W-1:0] lb_wd [4];

  assign px_ready = !col_valid || col_ready;
  assign accept   = px_valid && px_ready;
  assign xfer     = col_valid && col_ready;

  // A start-of-frame pixel is placed at row 0, col 0 whatever the counters say.
  assign x_use    = px_sof ? '0 : x;
  assign fill_use = px_sof ? 3'd0 : fill;
  assign x_last   = (x_use == X_W'(IMG_W - 1));

  assign lb_wd[0] = lb_rd[1];
  assign lb_wd[1] = lb_rd[2];
  assign lb_wd[2] = lb_rd[3];
  assign lb_wd[3] = px_in;

  for (genvar i = 0; i < 4; i++) begin : g_lb
    line_ram #(
      .DEPTH(IMG_W),
      .WIDTH(PIX_W),
      .AW   (X_W)
    ) u_lb (
      .clk    (clk),
      .wr_en  (accept),
      .addr   (x_use),
      .wr_data(lb_wd[i]),
      .rd_data(lb_rd[i])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x    <= '0;
      fill <= 3'd0;
    end else if (accept) begin
      x <= x_last ? '0 : x_use + X_W'(1);
      if (x_last && fill_use != FILL_FULL) fill <= fill_use + 3'd1;
      else                                 fill <= fill_use;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_valid <= 1'b0;
      col_out   <= '0;
      col_x     <= '0;
      col_eol   <= 1'b0;
    end else if (accept) begin
      col_valid <= (fill_use == FILL_FULL);
      if (fill_use == FILL_FULL) begin
        for (int i = 0; i < 4; i++) col_out[i] <= lb_rd[i];
        col_out[4] <= px_in;
        col_x      <= x_use;
        col_eol    <= x_last;
      end
    end else if (xfer) begin
      col_valid <= 1'b0;
    end
  end

endmodule
